// File: rtl/temporal_filter_pkg.sv
// Shared constants and types for the temporal pixel filters.
// Mode encodings, default frame geometry, stage metadata struct.
// Counter/address width helper used when sizing position counters.
package temporal_filter_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_EMA    = 2'd1;
  localparam logic [1:0] MODE_RESEED = 2'd2;

  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;

  // Per-beat control carried alongside the pixel from S1 into S2.
  typedef struct packed {
    logic       sop;
    logic       eop;
    logic       wr;   // beat is in range and its result is written back
    logic       ema;  // beat takes the filtered value instead of the input
    logic [2:0] k;
  } s1_meta_t;

  // Bits needed to index n distinct values (at least 1).
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/temporal_ema_channel.sv
// One colour channel of the EMA update: new = old + round((in - old) / 2^k).
// Latency: purely combinational.
// Backpressure: none; the parent pipeline freezes its inputs.
module temporal_ema_channel #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] old_val,
  input  logic [DATA_W-1:0] in_val,
  input  logic [2:0]        k,
  output logic [DATA_W-1:0] new_val
);

  // Two guard bits: one for the sign of the difference, one so the
  // rounding offset (up to 2^6) cannot overflow a full-scale step.
  logic signed [DATA_W+1:0] diff;
  logic signed [DATA_W+1:0] rnd;
  logic signed [DATA_W+1:0] step;

  // Signed difference, round-half-up offset, arithmetic shift, add back.
  always_comb begin
    diff = $signed({2'b00, in_val}) - $signed({2'b00, old_val});
    rnd  = '0;
    if (k != 3'd0) begin
      rnd = (DATA_W+2)'(1) << (k - 3'd1);
    end
    step    = (diff + rnd) >>> k;
    // The result is bounded by old and in, so the low bits of the sum are exact.
    new_val = old_val + step[DATA_W-1:0];
  end

endmodule

// File: rtl/temporal_ema_filter.sv
// Per-pixel temporal EMA over frames, history held in an external sync RAM.
// Latency: 2 cycles accept-to-out_valid (S1 read issue, S2 compute/write/output).
// Backpressure: whole pipeline stalls when out_valid && !out_ready; in_ready = advance.
module temporal_ema_filter
  import temporal_filter_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CHANNELS  = 3,
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int ADDR_W    = 19,
  parameter int K_DEFAULT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mode,
  input  logic [2:0]                 k_shift,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  input  logic                       in_sop,
  input  logic                       in_eop,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHANNELS*DATA_W-1:0] out_data,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic                       mem_rd_en,
  output logic [ADDR_W-1:0]          mem_rd_addr,
  input  logic [CHANNELS*DATA_W-1:0] mem_rd_data,
  output logic                       mem_wr_en,
  output logic [ADDR_W-1:0]          mem_wr_addr,
  output logic [CHANNELS*DATA_W-1:0] mem_wr_data
);

  localparam int PIX_W = CHANNELS * DATA_W;
  localparam int X_W   = addr_width(IMG_W);
  // y saturates at IMG_H so that long frames stay out of range.
  localparam int Y_W   = addr_width(IMG_H + 1);
  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);
  localparam logic [Y_W-1:0] Y_END  = Y_W'(IMG_H);

  logic              adv;
  logic              acc;
  logic [X_W-1:0]    x_cnt, cur_x;
  logic [Y_W-1:0]    y_cnt, cur_y;
  logic [ADDR_W-1:0] addr_cnt, cur_addr;
  logic              seen_sop;
  logic              primed;
  logic [1:0]        act_mode, cur_mode, sop_mode;
  logic [2:0]        act_k, cur_k;
  logic              in_range;
  logic              at_last;
  s1_meta_t          meta_nxt;

  logic              s1_vld;
  logic [PIX_W-1:0]  s1_dat;
  logic [ADDR_W-1:0] s1_addr;
  s1_meta_t          s1_meta;

  logic [PIX_W-1:0]  ema_dat;
  logic [PIX_W-1:0]  res_dat;

  assign adv         = !out_valid || out_ready;
  assign in_ready    = adv;
  assign acc         = in_valid && adv;
  // Gated by rst so no read is issued while the block is held in reset.
  assign mem_rd_en   = acc && rst;
  assign mem_rd_addr = cur_addr;
  // Reserved mode 3 collapses to bypass when latched.
  assign sop_mode    = (mode == MODE_EMA || mode == MODE_RESEED) ? mode : MODE_BYPASS;

  // Position, frame settings and S1 control for the beat currently offered.
  always_comb begin
    cur_x    = in_sop ? '0 : x_cnt;
    cur_y    = in_sop ? '0 : y_cnt;
    cur_addr = in_sop ? '0 : addr_cnt;
    cur_mode = in_sop ? sop_mode : act_mode;
    cur_k    = in_sop ? k_shift : act_k;
    in_range = (in_sop || seen_sop) && (cur_y < Y_END);
    at_last  = in_range && (cur_x == X_LAST) && (cur_y == Y_LAST);
    meta_nxt     = '0;
    meta_nxt.sop = in_sop;
    meta_nxt.eop = in_eop;
    meta_nxt.wr  = in_range && (cur_mode != MODE_BYPASS);
    meta_nxt.ema = in_range && (cur_mode == MODE_EMA) && primed;
    meta_nxt.k   = cur_k;
  end

  // Frame position counters, latched frame settings and the primed flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      addr_cnt <= '0;
      seen_sop <= 1'b0;
      primed   <= 1'b0;
      act_mode <= MODE_BYPASS;
      act_k    <= 3'(K_DEFAULT);
    end else if (acc) begin
      x_cnt    <= (cur_x == X_LAST) ? '0 : cur_x + X_W'(1);
      y_cnt    <= ((cur_x == X_LAST) && (cur_y != Y_END)) ? cur_y + Y_W'(1) : cur_y;
      addr_cnt <= in_range ? cur_addr + ADDR_W'(1) : cur_addr;
      seen_sop <= seen_sop || in_sop;
      if (in_sop) begin
        act_mode <= sop_mode;
        act_k    <= k_shift;
      end
      // A complete filtering frame primes; any other eop length unprimes.
      if (in_eop) begin
        primed <= at_last && (cur_mode != MODE_BYPASS);
      end else if (in_sop && (sop_mode == MODE_BYPASS)) begin
        primed <= 1'b0;
      end
    end
  end

  // S1: hold the accepted beat while its history word is being read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld  <= 1'b0;
      s1_dat  <= '0;
      s1_addr <= '0;
      s1_meta <= '0;
    end else if (adv) begin
      s1_vld  <= in_valid;
      s1_dat  <= in_data;
      s1_addr <= cur_addr;
      s1_meta <= meta_nxt;
    end
  end

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_chan
      temporal_ema_channel #(
        .DATA_W (DATA_W)
      ) u_chan (
        .old_val (mem_rd_data[c*DATA_W +: DATA_W]),
        .in_val  (s1_dat[c*DATA_W +: DATA_W]),
        .k       (s1_meta.k),
        .new_val (ema_dat[c*DATA_W +: DATA_W])
      );
    end
  endgenerate

  assign res_dat = s1_meta.ema ? ema_dat : s1_dat;

  // S2: register the output beat and issue a single-cycle write-back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      mem_wr_en <= 1'b0;
      if (adv) begin
        out_valid   <= s1_vld;
        out_data    <= res_dat;
        out_sop     <= s1_vld && s1_meta.sop;
        out_eop     <= s1_vld && s1_meta.eop;
        mem_wr_en   <= s1_vld && s1_meta.wr;
        mem_wr_addr <= s1_addr;
        mem_wr_data <= res_dat;
      end
    end
  end

endmodule

// File: tb/tb_temporal_ema_filter.sv
module tb_temporal_ema_filter;
  import temporal_filter_pkg::*;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 4;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int ADDR_W = 5;
  localparam int CH     = 3;
  localparam int PW     = CH * 8;
  localparam int BUDGET = 3000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [2:0]        k_shift = 3'd0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PW-1:0]     in_data = '0;
  logic              in_sop = 1'b0;
  logic              in_eop = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [PW-1:0]     out_data;
  logic              out_sop;
  logic              out_eop;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [PW-1:0]     mem_rd_data = '0;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [PW-1:0]     mem_wr_data;

  always #5 clk = ~clk;

  temporal_ema_filter #(
    .DATA_W(8), .CHANNELS(CH), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .K_DEFAULT(2)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .k_shift(k_shift),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  // External history RAM: synchronous read, data holds while rd_en is low.
  logic [PW-1:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
  end

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] px  [0:63];
  logic [PW-1:0] obs [0:63];
  logic [PW-1:0] ref_hist [0:NPIX-1];
  bit            ref_primed = 1'b0;

  function automatic int fdiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  // Reference EMA: old + floor((in - old + half) / 2^k) per channel.
  function automatic logic [PW-1:0] ema_px(input logic [PW-1:0] old, input logic [PW-1:0] inp, input int k);
    logic [PW-1:0] r;
    int o, i, d;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      o = int'(old[c*8 +: 8]);
      i = int'(inp[c*8 +: 8]);
      d = i - o + ((k > 0) ? (1 << (k - 1)) : 0);
      r[c*8 +: 8] = 8'(o + fdiv(d, 1 << k));
    end
    return r;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 64; i++) px[i] = PW'($urandom);
  endtask

  // Drive one frame of n beats from px[], check every output beat against the model.
  task automatic run_frame(input logic [1:0] md, input logic [2:0] k, input int n,
                           input int rdy_pct, input int vld_pct, input bit chk_lat);
    logic [PW-1:0] exp_q [$];
    int lat_q [$];
    int idx, outn, cyc, wr_cnt, exp_wr, acc_cyc;
    logic [PW-1:0] e;
    bit inr;
    idx = 0; outn = 0; cyc = 0; wr_cnt = 0; exp_wr = 0;
    if (md == MODE_BYPASS) ref_primed = 1'b0;
    for (int i = 0; i < n; i++) begin
      inr = (i < NPIX);
      if (inr && md == MODE_EMA && ref_primed) e = ema_px(ref_hist[i], px[i], int'(k));
      else e = px[i];
      if (inr && md != MODE_BYPASS) begin
        ref_hist[i] = e;
        exp_wr++;
      end
      exp_q.push_back(e);
    end
    ref_primed = (md != MODE_BYPASS) && (n == NPIX);

    while ((idx < n || outn < n) && cyc < BUDGET) begin
      @(negedge clk);
      out_ready = ($urandom_range(99) < rdy_pct);
      if (idx < n && $urandom_range(99) < vld_pct) begin
        in_valid = 1'b1;
        in_data  = px[idx];
        in_sop   = (idx == 0);
        in_eop   = (idx == n - 1);
      end else begin
        in_valid = 1'b0;
        in_data  = PW'($urandom);
        in_sop   = 1'b0;
        in_eop   = 1'b0;
      end
      // Settings away from sop are noise; only the sop beat may latch them.
      mode    = (idx == 0) ? md : 2'($urandom_range(3));
      k_shift = (idx == 0) ? k : 3'($urandom_range(7));
      #1;
      checks++;
      if (mem_rd_en !== (in_valid && in_ready)) begin
        errors++;
        $display("FAIL rd_en cyc %0d got %b want %b", cyc, mem_rd_en, in_valid && in_ready);
      end
      if (mem_wr_en === 1'b1) wr_cnt++;
      if (out_valid && out_ready) begin
        checks++;
        if (outn >= n) begin
          errors++;
          $display("FAIL extra_output got beat %0d want at most %0d", outn, n);
        end else begin
          obs[outn] = out_data;
          if (out_data !== exp_q[outn] || out_sop !== (outn == 0) || out_eop !== (outn == n - 1)) begin
            errors++;
            $display("FAIL pixel %0d got %h sop %b eop %b want %h sop %b eop %b", outn,
                     out_data, out_sop, out_eop, exp_q[outn], outn == 0, outn == n - 1);
          end
          acc_cyc = lat_q.pop_front();
          if (chk_lat) begin
            checks++;
            if (cyc - acc_cyc != 2) begin
              errors++;
              $display("FAIL latency pixel %0d got %0d want 2", outn, cyc - acc_cyc);
            end
          end
        end
        outn++;
      end
      if (in_valid && in_ready) begin
        lat_q.push_back(cyc);
        idx++;
      end
      cyc++;
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    checks++;
    if (outn != n) begin
      errors++;
      $display("FAIL frame_timeout got %0d outputs want %0d", outn, n);
    end
    checks++;
    if (wr_cnt != exp_wr) begin
      errors++;
      $display("FAIL write_count got %0d want %0d", wr_cnt, exp_wr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({out_valid, out_sop, out_eop, mem_rd_en, mem_wr_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000", {out_valid, out_sop, out_eop, mem_rd_en, mem_wr_en});
    end
    checks++;
    if (out_data !== '0 || mem_rd_addr !== '0 || mem_wr_addr !== '0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h want 0/0/0", out_data, mem_rd_addr, mem_wr_addr);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ref_primed = 1'b0;
  endtask

  task automatic test_bypass();
    for (int i = 0; i < 64; i++) px[i] = PW'({8'(i * 3), 8'(i * 2), 8'(i)});
    run_frame(MODE_BYPASS, 3'd2, NPIX, 100, 100, 1'b1);
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (obs[i] !== px[i]) begin
        errors++;
        $display("FAIL bypass_out %0d got %h want %h", i, obs[i], px[i]);
      end
    end
  endtask

  task automatic test_seed_filter();
    for (int i = 0; i < 64; i++) px[i] = 24'h000000;
    run_frame(MODE_EMA, 3'd2, NPIX, 100, 100, 1'b1);
    for (int i = 0; i < 64; i++) px[i] = 24'hC0C0C0;
    run_frame(MODE_EMA, 3'd2, NPIX, 100, 100, 1'b0);
    checks++;
    if (obs[0] !== 24'h303030 || obs[NPIX-1] !== 24'h303030) begin
      errors++;
      $display("FAIL frame_b got %h/%h want 303030", obs[0], obs[NPIX-1]);
    end
    run_frame(MODE_EMA, 3'd2, NPIX, 100, 100, 1'b0);
    checks++;
    if (obs[0] !== 24'h545454 || obs[NPIX-1] !== 24'h545454) begin
      errors++;
      $display("FAIL frame_c got %h/%h want 545454", obs[0], obs[NPIX-1]);
    end
  endtask

  task automatic test_rounding();
    fill_random();
    px[0] = 24'h030303; px[1] = 24'h000000;
    run_frame(MODE_RESEED, 3'd5, NPIX, 100, 100, 1'b0);
    fill_random();
    px[0] = 24'h000000; px[1] = 24'h030303;
    run_frame(MODE_EMA, 3'd1, NPIX, 100, 100, 1'b0);
    checks++;
    if (obs[0] !== 24'h020202 || obs[1] !== 24'h020202) begin
      errors++;
      $display("FAIL round_k1 got %h/%h want 020202/020202", obs[0], obs[1]);
    end
    fill_random();
    run_frame(MODE_EMA, 3'd0, NPIX, 100, 100, 1'b0);
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (obs[i] !== px[i]) begin
        errors++;
        $display("FAIL k0_out %0d got %h want %h", i, obs[i], px[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    fill_random();
    run_frame(MODE_EMA, 3'd3, NPIX, 30, 70, 1'b0);
    fill_random();
    run_frame(MODE_EMA, 3'd7, NPIX, 30, 100, 1'b0);
  endtask

  task automatic test_short_frame();
    fill_random();
    run_frame(MODE_EMA, 3'd2, 10, 100, 100, 1'b0);
    fill_random();
    run_frame(MODE_EMA, 3'd2, NPIX, 100, 100, 1'b0);
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (obs[i] !== px[i]) begin
        errors++;
        $display("FAIL short_reseed %0d got %h want %h", i, obs[i], px[i]);
      end
    end
  endtask

  task automatic test_long_frame();
    fill_random();
    run_frame(MODE_EMA, 3'd1, NPIX + 5, 60, 80, 1'b0);
    fill_random();
    run_frame(MODE_EMA, 3'd1, NPIX, 100, 100, 1'b0);
    checks++;
    if (obs[0] !== px[0] || obs[NPIX-1] !== px[NPIX-1]) begin
      errors++;
      $display("FAIL long_reseed got %h/%h want %h/%h", obs[0], obs[NPIX-1], px[0], px[NPIX-1]);
    end
  endtask

  task automatic test_reset_mid();
    int idx, cyc;
    fill_random();
    run_frame(MODE_EMA, 3'd2, NPIX, 100, 100, 1'b0);
    fill_random();
    idx = 0; cyc = 0;
    while (idx < 20 && cyc < BUDGET) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; in_sop = (idx == 0); in_eop = 1'b0;
      in_data = px[idx]; mode = MODE_EMA; k_shift = 3'd2;
      #1;
      if (in_valid && in_ready) idx++;
      cyc++;
    end
    @(negedge clk);
    rst = 1'b0;
    in_sop = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_sop, out_eop, mem_rd_en, mem_wr_en} !== 5'b0 || out_data !== '0 ||
        mem_rd_addr !== '0 || mem_wr_addr !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got %b %h %h %h want 00000 0 0 0",
               {out_valid, out_sop, out_eop, mem_rd_en, mem_wr_en}, out_data, mem_rd_addr, mem_wr_addr);
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if (mem_wr_en !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_hold got wr %b vld %b want 0 0", mem_wr_en, out_valid);
      end
    end
    in_valid = 1'b0;
    rst = 1'b1;
    ref_primed = 1'b0;
    fill_random();
    run_frame(MODE_EMA, 3'd2, NPIX, 100, 100, 1'b1);
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (obs[i] !== px[i]) begin
        errors++;
        $display("FAIL post_reset_seed %0d got %h want %h", i, obs[i], px[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
    for (int i = 0; i < NPIX; i++) ref_hist[i] = '0;
    test_reset();
    test_bypass();
    test_seed_filter();
    test_rounding();
    test_backpressure();
    test_short_frame();
    test_long_frame();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/temporal_ema_filter.md
Name: temporal_ema_filter

Overview:
- Parametrised successor to the fixed 4-frame box temporal filter. Per-pixel exponential moving average (EMA) over frames reduces sensor noise ahead of colour detection.
- Processes a valid/ready pixel stream with sop/eop. Tracks x,y internally.
- Frame history lives in an external synchronous RAM (one word per pixel), not in registers.
- Sits between the camera stream adapter and the image processor.

Parameters:
- DATA_W, 8, bits per colour channel.
- CHANNELS, 3, channels packed per pixel; channel 0 occupies the LSBs.
- IMG_W, 640, pixels per line.
- IMG_H, 480, lines per frame.
- ADDR_W, 19, history RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- K_DEFAULT, 2, EMA shift applied after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- mode  in  2  0=bypass, 1=EMA, 2=reseed, 3=reserved (treated as bypass); sampled at sop.
- k_shift  in  3  EMA weight; alpha = 2^-k, valid range 0..7; sampled at sop.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input accept.
- in_data  in  CHANNELS*DATA_W  input pixel.
- in_sop  in  1  first pixel of frame.
- in_eop  in  1  last pixel of frame.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accept.
- out_data  out  CHANNELS*DATA_W  filtered pixel.
- out_sop  out  1  sop aligned with out_data.
- out_eop  out  1  eop aligned with out_data.
- mem_rd_en  out  1  RAM read enable; read data is valid one cycle later and holds while low.
- mem_rd_addr  out  ADDR_W  read address.
- mem_rd_data  in  CHANNELS*DATA_W  read data.
- mem_wr_en  out  1  RAM write strobe.
- mem_wr_addr  out  ADDR_W  write address.
- mem_wr_data  out  CHANNELS*DATA_W  write data.

Behaviour:
- Reset:
  - out_valid, out_sop, out_eop, mem_rd_en and mem_wr_en are 0.
  - out_data, mem_rd_addr and mem_wr_addr are 0.
  - x=y=0, primed=0, active mode=0, active k=K_DEFAULT.
  - Reset mid-frame discards in-flight pixels; no partial RAM write may occur after rst falls.
- Pipeline:
  - Two stages: S1 accepts input and issues the read; S2 computes, writes back and registers the output.
  - Latency is 2 cycles from accept to out_valid.
  - adv = !out_valid || out_ready.
  - in_ready = adv. mem_rd_en = adv && in_valid. The pipeline freezes entirely when !adv.
  - A beat transfers when valid && ready on that side.
  - Full throughput is 1 pixel/cycle.
- Position counters:
  - A beat with in_sop forces (x,y)=(0,0) for that beat and latches mode and k_shift.
  - x increments per beat, wraps at IMG_W-1 and then increments y.
  - Address = y*IMG_W + x, computed incrementally; no multiplier.
- Out-of-range beats (y >= IMG_H, or data without any prior sop):
  - Passed through unfiltered.
  - mem_wr_en stays 0.
- primed flag:
  - Set when eop arrives on beat index IMG_W*IMG_H-1 of a mode 1 or mode 2 frame.
  - Cleared on a short or long frame (eop at any other index), on reset, and on any sop with mode=0.
- Per-pixel output and write-back by mode:
  - Mode 0: out = in; no write.
  - Mode 2, or mode 1 with primed=0: out = in; write in (seed).
  - Mode 1 with primed=1: out = EMA; write EMA.
- EMA per channel:
  - d = in - old, signed DATA_W+1 bits.
  - If k>0, add 2^(k-1) to d for rounding.
  - Arithmetic shift right by k.
  - new = old + shifted d.
  - The result always lies in [min(old,in), max(old,in)], so no clamp is required. k=0 gives new=in.
- Hazard: each address is touched once per frame, so no read/write forwarding is needed. A sop that arrives before the previous eop still restarts counters cleanly.
- out_sop and out_eop are delayed copies of in_sop and in_eop.

Decomposition:
- Shared include temporal_filter_pkg holds:
  - MODE_BYPASS, MODE_EMA, MODE_RESEED constants.
  - Default IMG_W and IMG_H.
  - The address-width function.
- One sub-module, temporal_ema_channel, computes the combinational EMA for one channel (DATA_W, k). It is instantiated CHANNELS times with a generate loop.

Test Plan:
- Bypass:
  - Stimulus: mode=0, one 640x480 frame of ramp data.
  - Required response: out_data == in_data 2 cycles later, mem_wr_en never 1, primed stays 0.
- Seed then filter:
  - Stimulus: frame A of constant 0x000000 with mode=1, then frame B of constant 0xC0C0C0 with k=2.
  - Required response: frame A passes through unchanged and is written. Frame B outputs 0x303030 (0+round(192/4)=48); frame C with the same 0xC0C0C0 input then outputs 0x545454 (48+36=84).
- Rounding/negative step:
  - Stimulus: old=3, in=0, k=1.
  - Required response: output 2. Also old=0, in=3, k=1 gives 2; k=0 gives output equal to in.
- Backpressure:
  - Stimulus: random out_ready at 30% duty during a primed frame.
  - Required response: no dropped or duplicated pixels, output matches a reference model, mem_rd_en low whenever in_ready is low.
- Short frame:
  - Stimulus: eop after 1000 pixels.
  - Required response: primed=0, so the next mode=1 frame reseeds (out = in).
- Reset mid-frame:
  - Stimulus: assert rst at pixel 5000.
  - Required response: all outputs 0 immediately, and the next frame is treated as unprimed.
